// File: rtl/fifo_arb_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arb_pkg
// Shared definitions for the FIFO write-port arbiter:
//   - arb_state_e : two-state arbiter FSM encoding (IDLE / GRANT)
//   - CNT_W()     : width of the per-grant beat counter for a given burst length
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // One extra bit over log2 so the counter can hold BURST_LEN itself.
  function automatic int CNT_W(input int burst_len);
    return $clog2(burst_len) + 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// ---------------------------------------------------------------------------
// rr_priority_picker
// Purely combinational round-robin picker. Scans the request vector starting
// one position after the pointer and wrapping, and returns the first
// requester found.
// Ports:
//   req        in  NUM_REQ : request vector
//   ptr        in  IDX_W   : index of the previous winner
//   winner     out NUM_REQ : one-hot winner, zero when no request
//   winner_idx out IDX_W   : binary index of the winner (0 when no request)
// ---------------------------------------------------------------------------
module rr_priority_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   winner_idx
);

  // Walk NUM_REQ positions from ptr+1 (modulo NUM_REQ); first hit wins.
  always_comb begin
    logic             found_s;
    logic [IDX_W-1:0] idx_s;
    winner     = '0;
    winner_idx = '0;
    found_s    = 1'b0;
    idx_s      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx_s = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (!found_s && req[idx_s]) begin
        winner[idx_s] = 1'b1;
        winner_idx    = idx_s;
        found_s       = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter sharing one async_fifo write port among NUM_REQ
// requesters in the write clock domain. Each grant lasts up to BURST_LEN
// beats; every re-arbitration passes through IDLE (one bubble cycle).
// Ports:
//   clk_i     in  1                  : write-domain clock
//   rst_i     in  1                  : asynchronous active-high reset
//   valid_i   in  NUM_REQ            : per-requester beat valid
//   data_i    in  NUM_REQ*DATA_WIDTH : packed beats, requester k at [k*DW +: DW]
//   ready_o   out NUM_REQ            : per-requester accept
//   full_i    in  1                  : FIFO full flag
//   wr_en_o   out 1                  : FIFO write enable
//   wr_data_o out DATA_WIDTH         : FIFO write data
//   grant_o   out NUM_REQ            : registered one-hot grant, zero when idle
//   busy_o    out 1                  : high while in GRANT
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_i,
  output logic [NUM_REQ-1:0]            ready_o,
  input  logic                          full_i,
  output logic                          wr_en_o,
  output logic [DATA_WIDTH-1:0]         wr_data_o,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o
);

  import fifo_arb_pkg::*;

  localparam int               IDX_W    = $clog2(NUM_REQ);
  localparam int               CW       = CNT_W(BURST_LEN);
  localparam logic [CW-1:0]    CNT_LAST = CW'(BURST_LEN - 1);
  localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(NUM_REQ - 1);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [NUM_REQ-1:0] pick_winner_s;
  logic [IDX_W-1:0]   pick_idx_s;
  logic               grant_valid_s;
  logic               xfer_s;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req        (valid_i),
    .ptr        (ptr_q),
    .winner     (pick_winner_s),
    .winner_idx (pick_idx_s)
  );

  // A beat moves only when the granted requester is valid and the FIFO has room.
  assign grant_valid_s = |(grant_q & valid_i);
  assign xfer_s        = grant_valid_s & ~full_i;

  assign wr_en_o = xfer_s;
  assign ready_o = grant_q & {NUM_REQ{~full_i}};
  assign grant_o = grant_q;
  assign busy_o  = (state_q == ST_GRANT);

  // AND-OR data mux driven by the registered grant; zero when idle.
  always_comb begin
    wr_data_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      wr_data_o = wr_data_o | (data_i[k*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant_q[k]}});
    end
  end

  // Next-state logic: arbitrate in IDLE, count beats and detect release/burst end in GRANT.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|valid_i) begin
          state_d = ST_GRANT;
          grant_d = pick_winner_s;
          ptr_d   = pick_idx_s;
          cnt_d   = '0;
        end else begin
          grant_d = '0;
        end
      end
      ST_GRANT: begin
        // Release wins even during a full stall.
        if (!grant_valid_s) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end else if (xfer_s) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_IDLE;
            grant_d = '0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          // Full stall: hold grant and count.
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Arbiter state registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= PTR_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Directed checks of fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8, BURST_LEN=4)
// followed by a random-traffic scoreboard. Inputs change 1 ns after the
// rising edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int BL = 4;

  logic              clk = 1'b0;
  logic              rst_i;
  logic [NR-1:0]     valid_i;
  logic [NR*DW-1:0]  data_i;
  logic [NR-1:0]     ready_o;
  logic              full_i;
  logic              wr_en_o;
  logic [DW-1:0]     wr_data_o;
  logic [NR-1:0]     grant_o;
  logic              busy_o;

  int          n_checks = 0;
  int          n_errors = 0;
  int          seq[NR];
  int          exp_seq[NR];
  logic [7:0]  base[NR];
  logic [NR-1:0] hs;
  int          n_wr;
  int          kk;

  fifo_wr_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .BURST_LEN  (BL)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .data_i    (data_i),
    .ready_o   (ready_o),
    .full_i    (full_i),
    .wr_en_o   (wr_en_o),
    .wr_data_o (wr_data_o),
    .grant_o   (grant_o),
    .busy_o    (busy_o)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Each requester presents base + number of beats it has handed off so far.
  task automatic drive_data();
    for (int k = 0; k < NR; k++) data_i[k*DW +: DW] = base[k] + 8'(seq[k]);
  endtask

  // Finish the cycle: record handshakes, cross the edge, advance requesters.
  task automatic adv();
    hs = valid_i & ready_o;
    @(posedge clk);
    #1;
    for (int k = 0; k < NR; k++) if (hs[k]) seq[k]++;
    drive_data();
  endtask

  task automatic step(input string tag, input logic [3:0] g, input logic we,
                      input logic [7:0] d, input logic chk_d, input logic bsy);
    @(negedge clk);
    chk({tag, "_grant"}, 32'(grant_o), 32'(g));
    chk({tag, "_wr_en"}, 32'(wr_en_o), 32'(we));
    chk({tag, "_ready"}, 32'(ready_o), 32'(g & {NR{~full_i}}));
    chk({tag, "_busy"},  32'(busy_o),  32'(bsy));
    if (chk_d) chk({tag, "_data"}, 32'(wr_data_o), 32'(d));
    adv();
  endtask

  task automatic do_reset();
    rst_i   = 1'b1;
    valid_i = '0;
    full_i  = 1'b0;
    for (int k = 0; k < NR; k++) begin
      seq[k]  = 0;
      base[k] = 8'h00;
    end
    drive_data();
    @(posedge clk);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    logic [3:0] g;
    logic [7:0] d;
    int         c5;

    rst_i   = 1'b1;
    valid_i = '0;
    full_i  = 1'b0;
    for (int k = 0; k < NR; k++) begin
      seq[k]  = 0;
      base[k] = 8'h00;
    end
    drive_data();

    // Reset values while reset is held.
    step("rst", 4'h0, 1'b0, 8'h00, 1'b1, 1'b0);
    rst_i = 1'b0;

    // Test 1: requester 2 streams A0..A7, no back-pressure.
    base[2] = 8'hA0;
    drive_data();
    valid_i = 4'b0100;
    for (int c = 0; c < 10; c++) begin
      if (c == 0 || c == 5) begin
        step("t1_bubble", 4'h0, 1'b0, 8'h00, 1'b1, 1'b0);
      end else begin
        d = (c < 5) ? 8'(8'hA0 + c - 1) : 8'(8'hA0 + c - 2);
        step("t1_beat", 4'b0100, 1'b1, d, 1'b1, 1'b1);
      end
    end
    valid_i = '0;
    step("t1_end", 4'h0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Test 2: all four requesters valid; round-robin 0,1,2,3,0.
    do_reset();
    for (int k = 0; k < NR; k++) base[k] = 8'(16 * k);
    drive_data();
    valid_i = 4'hF;
    for (int c = 0; c < 25; c++) begin
      c5 = c % 5;
      if (c5 == 0) begin
        step("t2_bubble", 4'h0, 1'b0, 8'h00, 1'b1, 1'b0);
      end else begin
        g = 4'(1 << ((c / 5) % 4));
        d = 8'(16 * ((c / 5) % 4) + (c5 - 1) + 4 * (c / 20));
        step("t2_beat", g, 1'b1, d, 1'b1, 1'b1);
      end
    end

    // Test 3: full stall for 3 cycles after beat 2.
    do_reset();
    base[0] = 8'h30;
    drive_data();
    valid_i = 4'b0001;
    step("t3_idle", 4'h0, 1'b0, 8'h00, 1'b1, 1'b0);
    step("t3_b1",   4'b0001, 1'b1, 8'h30, 1'b1, 1'b1);
    step("t3_b2",   4'b0001, 1'b1, 8'h31, 1'b1, 1'b1);
    full_i = 1'b1;
    for (int c = 0; c < 3; c++) step("t3_stall", 4'b0001, 1'b0, 8'h32, 1'b1, 1'b1);
    full_i = 1'b0;
    step("t3_b3",   4'b0001, 1'b1, 8'h32, 1'b1, 1'b1);
    step("t3_b4",   4'b0001, 1'b1, 8'h33, 1'b1, 1'b1);
    valid_i = '0;
    step("t3_end",  4'h0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Test 4: requester 1 releases after 2 beats; requester 3 waiting.
    do_reset();
    base[1] = 8'h10;
    base[3] = 8'h70;
    drive_data();
    valid_i = 4'b1010;
    step("t4_idle", 4'h0, 1'b0, 8'h00, 1'b1, 1'b0);
    step("t4_b1",   4'b0010, 1'b1, 8'h10, 1'b1, 1'b1);
    step("t4_b2",   4'b0010, 1'b1, 8'h11, 1'b1, 1'b1);
    valid_i = 4'b1000;
    step("t4_rel",  4'b0010, 1'b0, 8'h12, 1'b1, 1'b1);
    step("t4_idle2", 4'h0, 1'b0, 8'h00, 1'b1, 1'b0);
    step("t4_r3",   4'b1000, 1'b1, 8'h70, 1'b1, 1'b1);
    valid_i = '0;

    // Test 5: reset pulse during beat 2 of a grant to requester 0.
    do_reset();
    base[0] = 8'h50;
    base[1] = 8'h60;
    drive_data();
    valid_i = 4'b0011;
    step("t5_idle", 4'h0, 1'b0, 8'h00, 1'b1, 1'b0);
    step("t5_b1",   4'b0001, 1'b1, 8'h50, 1'b1, 1'b1);
    rst_i = 1'b1;
    step("t5_rst",  4'h0, 1'b0, 8'h00, 1'b1, 1'b0);
    rst_i = 1'b0;
    step("t5_idle2", 4'h0, 1'b0, 8'h00, 1'b1, 1'b0);
    step("t5_regrant", 4'b0001, 1'b1, 8'h51, 1'b1, 1'b1);
    valid_i = '0;

    // Test 6: random valid/full traffic with an in-order scoreboard.
    do_reset();
    for (int k = 0; k < NR; k++) begin
      base[k]    = 8'(64 * k);
      exp_seq[k] = 0;
    end
    drive_data();
    n_wr = 0;
    for (int c = 0; c < 300; c++) begin
      for (int k = 0; k < NR; k++) begin
        if (!valid_i[k]) valid_i[k] = 1'($urandom_range(1, 0));
        else if ($urandom_range(3, 0) == 0) valid_i[k] = 1'b0;
        else valid_i[k] = 1'b1;
      end
      full_i = ($urandom_range(2, 0) == 0);
      @(negedge clk);
      chk("t6_onehot", 32'($onehot0(grant_o)), 32'd1);
      chk("t6_ready_sub", 32'(ready_o & ~grant_o), 32'd0);
      chk("t6_wr_hs", 32'(wr_en_o), 32'(|(valid_i & grant_o) & ~full_i));
      if (wr_en_o) begin
        chk("t6_wr_full", 32'(full_i), 32'd0);
        kk = 0;
        for (int k = 0; k < NR; k++) if (grant_o[k]) kk = k;
        chk("t6_data", 32'(wr_data_o), 32'(base[kk] + 8'(exp_seq[kk])));
        exp_seq[kk]++;
        n_wr++;
      end
      adv();
    end
    valid_i = '0;
    full_i  = 1'b0;
    for (int k = 0; k < NR; k++) chk("t6_count", 32'(exp_seq[k]), 32'(seq[k]));
    chk("t6_some_writes", 32'(n_wr > 0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
